// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the Wishbone masters, the round-robin arbiter and the interconnect port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface wb_rr_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned NM = 2
);
    localparam int unsigned SEL = DW / 8;

    logic [NM-1:0]     wbm_cyc_i;
    logic [NM-1:0]     wbm_stb_i;
    logic [NM-1:0]     wbm_we_i;
    logic [NM*SEL-1:0] wbm_sel_i;
    logic [NM*AW-1:0]  wbm_adr_i;
    logic [NM*DW-1:0]  wbm_dat_i;
    logic [DW-1:0]     wbm_dat_o;
    logic [NM-1:0]     wbm_ack_o;
    logic [NM-1:0]     wbm_err_o;

    logic              wbs_cyc_o;
    logic              wbs_stb_o;
    logic              wbs_we_o;
    logic [SEL-1:0]    wbs_sel_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [DW-1:0]     wbs_dat_i;
    logic              wbs_ack_i;

    modport slave (
        input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        input  wbs_dat_i, wbs_ack_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
    );

    modport master (
        output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        output wbs_dat_i, wbs_ack_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one port into the interconnect.
// A granted master owns the bus for its whole cycle; a watchdog errors out hung accesses.
module wb_rr_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned NM      = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_rr_arbiter_if.slave bus
);
    localparam int unsigned SEL = DW / 8;
    localparam int unsigned GW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned WW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [GW-1:0]  gnt;
    logic [GW-1:0]  last;
    logic [GW-1:0]  pick;
    logic [WW-1:0]  wd;
    logic           found;
    int unsigned    idx;
    logic           req_any;
    logic           timeout_c;

    logic           cyc_g;
    logic           stb_g;
    logic           we_g;
    logic [SEL-1:0] sel_g;
    logic [AW-1:0]  adr_g;
    logic [DW-1:0]  dat_g;

    assign req_any = |bus.wbm_cyc_i;

    // Signals of the currently granted master
    always_comb begin
        cyc_g = 1'b0;
        stb_g = 1'b0;
        we_g  = 1'b0;
        sel_g = '0;
        adr_g = '0;
        dat_g = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (gnt == GW'(k)) begin
                cyc_g = bus.wbm_cyc_i[GW'(k)];
                stb_g = bus.wbm_stb_i[GW'(k)];
                we_g  = bus.wbm_we_i[GW'(k)];
                sel_g = SEL'(bus.wbm_sel_i >> (k * SEL));
                adr_g = AW'(bus.wbm_adr_i >> (k * AW));
                dat_g = DW'(bus.wbm_dat_i >> (k * DW));
            end
        end
    end

    // First requester at or after last+1, wrapping
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NM; i++) begin
            idx = (32'(last) + i) % NM;
            if (!found && bus.wbm_cyc_i[GW'(idx)]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    // Ack arriving in the same cycle as the limit takes precedence over the error
    assign timeout_c = (state == BUSY) && cyc_g && stb_g && !bus.wbs_ack_i
                       && (wd == WW'(TIMEOUT));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_any) state_nxt = BUSY;
            BUSY: begin
                if (!cyc_g) begin
                    state_nxt = IDLE;
                end else if (timeout_c) begin
                    state_nxt = ERR;
                end
            end
            ERR:  if (!cyc_g) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gnt  <= '0;
            last <= GW'(NM - 1);
            wd   <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                gnt <= pick;
            end
            if (state != IDLE && state_nxt == IDLE) begin
                last <= gnt;
            end
            if (state == BUSY && state_nxt == BUSY && stb_g && !bus.wbs_ack_i) begin
                if (wd != WW'(TIMEOUT)) begin
                    wd <= wd + 1'b1;
                end
            end else begin
                wd <= '0;
            end
        end
    end

    // Slave port and ack/data return are a pure mux while BUSY
    always_comb begin
        bus.wbs_cyc_o = 1'b0;
        bus.wbs_stb_o = 1'b0;
        bus.wbs_we_o  = 1'b0;
        bus.wbs_sel_o = '0;
        bus.wbs_adr_o = '0;
        bus.wbs_dat_o = '0;
        bus.wbm_dat_o = '0;
        bus.wbm_ack_o = '0;
        bus.wbm_err_o = '0;
        if (state == BUSY) begin
            bus.wbs_cyc_o = cyc_g;
            bus.wbs_stb_o = stb_g;
            bus.wbs_we_o  = we_g;
            bus.wbs_sel_o = sel_g;
            bus.wbs_adr_o = adr_g;
            bus.wbs_dat_o = dat_g;
            bus.wbm_dat_o = bus.wbs_dat_i;
            bus.wbm_ack_o = NM'(bus.wbs_ack_i) << gnt;
            bus.wbm_err_o = NM'(timeout_c) << gnt;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (NM=4, TIMEOUT=8): vector table, directed corner
// sequences, and randomized traffic compared against a cycle-level reference model.
module tb_wb_rr_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned NM  = 4;
    localparam int unsigned TO  = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // reference model: 0 idle, 1 owned, 2 errored
    int ms, mo, ml, mw;

    typedef struct {
        logic [3:0]  cyc;
        logic        ack;
        logic        exp_cyc;
        logic [3:0]  exp_ack;
        logic [31:0] exp_adr;
    } vec_t;
    vec_t tbl [15];

    wb_rr_arbiter_if #(.AW(AW), .DW(DW), .NM(NM)) bus ();

    wb_rr_arbiter #(.AW(AW), .DW(DW), .NM(NM), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] adr_of(input int k);
        return 32'h2000_0000 + 32'(k * 16);
    endfunction

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_we_i  = '0;
        bus.wbm_sel_i = '1;
        for (int k = 0; k < NM; k++) begin
            bus.wbm_adr_i[k*AW +: AW] = adr_of(k);
            bus.wbm_dat_i[k*DW +: DW] = 32'hD000_0000 + 32'(k);
        end
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = 1'b0;
    endtask

    task automatic do_reset;
        clear_in();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    task automatic model_check;
        logic       ec, es, ew;
        logic [3:0] esel, eack, eerr;
        logic [31:0] eadr, edat, erd;
        ec = 0; es = 0; ew = 0; esel = 0; eack = 0; eerr = 0; eadr = 0; edat = 0; erd = 0;
        if (ms == 1) begin
            ec   = bus.wbm_cyc_i[mo];
            es   = bus.wbm_stb_i[mo];
            ew   = bus.wbm_we_i[mo];
            esel = bus.wbm_sel_i[mo*4 +: 4];
            eadr = bus.wbm_adr_i[mo*AW +: AW];
            edat = bus.wbm_dat_i[mo*DW +: DW];
            erd  = bus.wbs_dat_i;
            if (bus.wbs_ack_i) eack[mo] = 1'b1;
            else if (ec && es && mw == int'(TO)) eerr[mo] = 1'b1;
        end
        chk("rnd_ctl", {61'd0, bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o}, {61'd0, ec, es, ew});
        chk("rnd_sel", 64'(bus.wbs_sel_o), 64'(esel));
        chk("rnd_adr", 64'(bus.wbs_adr_o), 64'(eadr));
        chk("rnd_wdat", 64'(bus.wbs_dat_o), 64'(edat));
        chk("rnd_rdat", 64'(bus.wbm_dat_o), 64'(erd));
        chk("rnd_ack", 64'(bus.wbm_ack_o), 64'(eack));
        chk("rnd_err", 64'(bus.wbm_err_o), 64'(eerr));
    endtask

    task automatic model_step;
        int cand;
        bit done;
        if (rst) begin
            ms = 0; ml = NM - 1; mw = 0;
        end else if (ms == 0) begin
            if (bus.wbm_cyc_i != 0) begin
                done = 0;
                for (int i = 1; i <= NM; i++) begin
                    cand = (ml + i) % NM;
                    if (!done && bus.wbm_cyc_i[cand]) begin
                        mo = cand; done = 1;
                    end
                end
                ms = 1; mw = 0;
            end
        end else if (ms == 1) begin
            if (!bus.wbm_cyc_i[mo]) begin
                ml = mo; ms = 0; mw = 0;
            end else if (bus.wbm_stb_i[mo] && !bus.wbs_ack_i) begin
                if (mw == int'(TO)) begin
                    ms = 2; mw = 0;
                end else begin
                    mw = mw + 1;
                end
            end else begin
                mw = 0;
            end
        end else begin
            if (!bus.wbm_cyc_i[mo]) begin
                ml = mo; ms = 0;
            end
        end
    endtask

    initial begin
        int cnt, got;
        logic [3:0] drop;

        tbl[0]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[1]  = '{4'b0011, 1'b0, 1'b1, 4'b0000, adr_of(0)};
        tbl[2]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, adr_of(0)};
        tbl[3]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, adr_of(0)};
        tbl[4]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[5]  = '{4'b0010, 1'b1, 1'b1, 4'b0010, adr_of(1)};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, adr_of(1)};
        tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[8]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, adr_of(2)};
        tbl[9]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, adr_of(2)};
        tbl[10] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[11] = '{4'b1111, 1'b1, 1'b1, 4'b1000, adr_of(3)};
        tbl[12] = '{4'b0111, 1'b0, 1'b0, 4'b0000, adr_of(3)};
        tbl[13] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[14] = '{4'b1111, 1'b1, 1'b1, 4'b0001, adr_of(0)};

        // reset state
        rst = 1'b1;
        clear_in();
        nxt();
        do_reset();
        bus.wbs_dat_i = 32'hDEAD_BEEF;
        bus.wbs_ack_i = 1'b1;
        #2;
        chk("rst_cyc", 64'(bus.wbs_cyc_o), 64'd0);
        chk("rst_ack", 64'(bus.wbm_ack_o), 64'd0);
        chk("rst_err", 64'(bus.wbm_err_o), 64'd0);
        chk("rst_rdat", 64'(bus.wbm_dat_o), 64'd0);
        nxt();

        // single master write then read back
        do_reset();
        bus.wbm_cyc_i = 4'b0001; bus.wbm_stb_i = 4'b0001; bus.wbm_we_i = 4'b0001;
        bus.wbm_adr_i[31:0] = 32'h2000_0000;
        bus.wbm_dat_i[31:0] = 32'hA5A5_0001;
        bus.wbm_sel_i[3:0]  = 4'hF;
        #2 chk("sm_arb_cycle", 64'(bus.wbs_cyc_o), 64'd0);
        nxt();
        #2;
        chk("sm_wr_cyc", 64'(bus.wbs_cyc_o), 64'd1);
        chk("sm_wr_we", 64'(bus.wbs_we_o), 64'd1);
        chk("sm_wr_adr", 64'(bus.wbs_adr_o), 64'h2000_0000);
        chk("sm_wr_dat", 64'(bus.wbs_dat_o), 64'hA5A5_0001);
        bus.wbs_ack_i = 1'b1;
        #1 chk("sm_wr_ack", 64'(bus.wbm_ack_o), 64'b0001);
        nxt();
        bus.wbs_ack_i = 1'b0; bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0; bus.wbm_we_i = '0;
        nxt();
        bus.wbm_cyc_i = 4'b0001; bus.wbm_stb_i = 4'b0001;
        nxt();
        nxt();
        bus.wbs_ack_i = 1'b1; bus.wbs_dat_i = 32'hA5A5_0001;
        #2;
        chk("sm_rd_we", 64'(bus.wbs_we_o), 64'd0);
        chk("sm_rd_dat", 64'(bus.wbm_dat_o), 64'hA5A5_0001);
        chk("sm_rd_ack", 64'(bus.wbm_ack_o), 64'b0001);
        nxt();

        // vector table: contention and round-robin rotation from reset
        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.wbm_cyc_i = tbl[i].cyc;
            bus.wbm_stb_i = tbl[i].cyc;
            bus.wbs_ack_i = tbl[i].ack;
            #2;
            chk($sformatf("tbl%0d_cyc", i), 64'(bus.wbs_cyc_o), 64'(tbl[i].exp_cyc));
            chk($sformatf("tbl%0d_stb", i), 64'(bus.wbs_stb_o), 64'(tbl[i].exp_cyc));
            chk($sformatf("tbl%0d_ack", i), 64'(bus.wbm_ack_o), 64'(tbl[i].exp_ack));
            chk($sformatf("tbl%0d_err", i), 64'(bus.wbm_err_o), 64'd0);
            chk($sformatf("tbl%0d_adr", i), 64'(bus.wbs_adr_o), 64'(tbl[i].exp_adr));
            nxt();
        end

        // fairness: all four request continuously with single-beat cycles
        do_reset();
        cnt = 0;
        drop = '0;
        for (int c = 0; c < 60 && cnt < 6; c++) begin
            bus.wbm_cyc_i = 4'hF & ~drop;
            bus.wbm_stb_i = 4'hF & ~drop;
            bus.wbs_ack_i = 1'b0;
            drop = '0;
            #1;
            if (bus.wbs_cyc_o) begin
                got = int'((bus.wbs_adr_o - 32'h2000_0000) >> 4);
                chk($sformatf("fair_grant%0d", cnt), 64'(got), 64'(cnt % 4));
                drop = 4'(1 << got);
                bus.wbs_ack_i = 1'b1;
                cnt++;
            end
            nxt();
        end
        chk("fair_count", 64'(cnt), 64'd6);

        // watchdog timeout, then the other master reuses the bus
        do_reset();
        bus.wbm_cyc_i = 4'b0011; bus.wbm_stb_i = 4'b0011;
        nxt();
        for (int w = 0; w < 8; w++) begin
            #2 chk($sformatf("to_wait%0d_err", w), 64'(bus.wbm_err_o), 64'd0);
            nxt();
        end
        #2;
        chk("to_err_pulse", 64'(bus.wbm_err_o), 64'b0001);
        chk("to_no_ack", 64'(bus.wbm_ack_o), 64'd0);
        chk("to_cyc_held", 64'(bus.wbs_cyc_o), 64'd1);
        nxt();
        bus.wbm_cyc_i = 4'b0010; bus.wbm_stb_i = 4'b0010;
        #2;
        chk("to_err_cyc", 64'(bus.wbs_cyc_o), 64'd0);
        chk("to_err_once", 64'(bus.wbm_err_o), 64'd0);
        nxt();
        nxt();
        bus.wbs_ack_i = 1'b1;
        #2;
        chk("to_m1_adr", 64'(bus.wbs_adr_o), 64'(adr_of(1)));
        chk("to_m1_ack", 64'(bus.wbm_ack_o), 64'b0010);
        nxt();

        // ack coinciding with the limit wins
        do_reset();
        bus.wbm_cyc_i = 4'b0001; bus.wbm_stb_i = 4'b0001;
        nxt();
        for (int w = 0; w < 8; w++) nxt();
        bus.wbs_ack_i = 1'b1;
        #2;
        chk("lim_ack", 64'(bus.wbm_ack_o), 64'b0001);
        chk("lim_err", 64'(bus.wbm_err_o), 64'd0);
        nxt();
        bus.wbs_ack_i = 1'b0;
        #2;
        chk("lim_still_busy", 64'(bus.wbs_cyc_o), 64'd1);
        chk("lim_err_after", 64'(bus.wbm_err_o), 64'd0);
        nxt();

        // reset during m1 ownership
        do_reset();
        bus.wbm_cyc_i = 4'b0010; bus.wbm_stb_i = 4'b0010;
        nxt();
        bus.wbm_cyc_i = 4'b0011; bus.wbm_stb_i = 4'b0011;
        bus.wbs_ack_i = 1'b1; bus.wbs_dat_i = 32'hFFFF_FFFF;
        #2 chk("mr_m1_ack", 64'(bus.wbm_ack_o), 64'b0010);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #2;
        chk("mr_cyc", 64'(bus.wbs_cyc_o), 64'd0);
        chk("mr_ack", 64'(bus.wbm_ack_o), 64'd0);
        chk("mr_rdat", 64'(bus.wbm_dat_o), 64'd0);
        nxt();
        #2;
        chk("mr_regrant_adr", 64'(bus.wbs_adr_o), 64'(adr_of(0)));
        chk("mr_regrant_ack", 64'(bus.wbm_ack_o), 64'b0001);
        nxt();

        // randomized traffic against the reference model
        do_reset();
        ms = 0; ml = NM - 1; mw = 0; mo = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(0, 7) == 0) bus.wbm_cyc_i[k] = ~bus.wbm_cyc_i[k];
                if ($urandom_range(0, 7) == 0) bus.wbm_stb_i[k] = ~bus.wbm_stb_i[k];
            end
            bus.wbm_we_i  = 4'($urandom);
            bus.wbm_sel_i = 16'($urandom);
            bus.wbm_adr_i = {$urandom, $urandom, $urandom, $urandom};
            bus.wbm_dat_i = {$urandom, $urandom, $urandom, $urandom};
            bus.wbs_dat_i = $urandom;
            bus.wbs_ack_i = ($urandom_range(0, (c < 1500) ? 2 : 15) == 0);
            #2;
            model_check();
            model_step();
            nxt();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
